// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate-array operand sequencer.
package gate_seq_pkg;

  localparam int unsigned PHASE_W = 2;

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_RUN  = 2'd1,
    ST_AUTO_HOLD = 2'd2
  } state_t;

  // {a,b} per phase, entry 0 in the low bits: 00,01,11,10
  localparam logic [7:0] GRAY_TABLE = 8'b10_11_01_00;

  function automatic logic [1:0] gray_decode(input logic [PHASE_W-1:0] ph);
    return GRAY_TABLE[{ph, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer + counting debouncer; emits a one-cycle pulse on an
// accepted press (0->1 of the debounced level), nothing on release.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_pulse <= 1'b0;
      // any sample agreeing with the accepted level restarts the run
      if (r_s2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_s2;
          r_pulse <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level       = r_level;
  assign press_pulse = r_pulse;

endmodule

// File: rtl/gate_sequencer.sv
// Operand sequencer for the two-input gate array: MANUAL follows switches,
// AUTO steps through all operand pairs. Define GATE_SEQ_GRAY_EN for Gray order.
module gate_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sw,
  input  logic              mode_sw,
  input  logic              step_btn,
  output logic              a,
  output logic              b,
  output logic [PHASE_W-1:0] phase,
  output logic              auto_active
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [1:0]         r_sw_s1;
  logic [1:0]         r_sw_s2;
  logic               r_mode_s1;
  logic               r_mode_s2;
  logic [1:0]         r_man_ab;
  state_t             r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [PRE_W-1:0]   r_presc;
  logic               r_auto_active;

  state_t             w_state_nxt;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [PRE_W-1:0]   w_presc_nxt;
  logic               w_tick;
  logic               w_press;
  logic               w_unused_btn_level;
  logic [1:0]         w_ab;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (step_btn),
    .level      (w_unused_btn_level),
    .press_pulse(w_press)
  );

  assign w_tick = (r_state == ST_AUTO_RUN) && (r_presc == PRE_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_MANUAL:    if (r_mode_s2) w_state_nxt = ST_AUTO_RUN;
      ST_AUTO_RUN:  if (!r_mode_s2) w_state_nxt = ST_MANUAL;
                    else if (w_press) w_state_nxt = ST_AUTO_HOLD;
      ST_AUTO_HOLD: if (!r_mode_s2) w_state_nxt = ST_MANUAL;
                    else if (w_press) w_state_nxt = ST_AUTO_RUN;
      default:      w_state_nxt = ST_MANUAL;
    endcase
  end

  // Clearing on both leaving and sitting in MANUAL gives AUTO_RUN entry a fresh
  // phase/prescaler; a tick still advances phase when a press moves RUN->HOLD.
  always_comb begin
    w_phase_nxt = r_phase;
    w_presc_nxt = r_presc;
    if ((r_state == ST_MANUAL) || (w_state_nxt == ST_MANUAL)) begin
      w_phase_nxt = '0;
      w_presc_nxt = '0;
    end else if (r_state == ST_AUTO_RUN) begin
      if (w_tick) begin
        w_presc_nxt = '0;
        w_phase_nxt = r_phase + 1'b1;
      end else begin
        w_presc_nxt = r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1       <= '0;
      r_sw_s2       <= '0;
      r_mode_s1     <= 1'b0;
      r_mode_s2     <= 1'b0;
      r_man_ab      <= '0;
      r_state       <= ST_MANUAL;
      r_phase       <= '0;
      r_presc       <= '0;
      r_auto_active <= 1'b0;
    end else begin
      r_sw_s1       <= sw;
      r_sw_s2       <= r_sw_s1;
      r_mode_s1     <= mode_sw;
      r_mode_s2     <= r_mode_s1;
      r_man_ab      <= r_sw_s2;
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_presc       <= w_presc_nxt;
      r_auto_active <= (w_state_nxt == ST_AUTO_RUN);
    end
  end

  always_comb begin
    w_ab = r_man_ab;
    if (r_state != ST_MANUAL) begin
`ifdef GATE_SEQ_GRAY_EN
      w_ab = gray_decode(r_phase);
`else
      w_ab = r_phase;
`endif
    end
  end

  assign a           = w_ab[1];
  assign b           = w_ab[0];
  assign phase       = r_phase;
  assign auto_active = r_auto_active;

endmodule
